hdc_stream_classifier: RTL

- Next-generation HDC classification engine: binary (bipolar-encoded) hypervectors, time-multiplexed over a streamed class memory instead of fully parallel partial-dot units.
- Per class: accumulates XNOR-popcount similarity between the query and each class HV, LANES bits per beat.
- Tracks a running argmax across classes and reports the predicted label and best score.
- Sits between the class-HV memory streamer and the system controller; replaces the fixed-width top-level dot/max path.

---
 rtl/hdc_stream_classifier.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/hdc_stream_classifier.sv
// Streamed binary HDC classifier: XNOR-popcount per class, running argmax.
// Optional reject threshold port pair enabled by HDC_REJECT_THRESH_EN.
module hdc_stream_classifier #(
   parameter int D = 8192,
   parameter int LANES = 256,
   parameter int NUM_C = 10,
   localparam int CHUNKS = D / LANES,
   localparam int SCORE_W = $clog2(D + 1),
   localparam int LBL_W = $clog2(NUM_C),
   localparam int CK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [D-1:0]       in_hv,
   input  logic               cls_valid,
   input  logic [LANES-1:0]   cls_data,
   output logic               cls_ready,
   output logic [LBL_W-1:0]   cls_class,
   output logic [CK_W-1:0]    cls_chunk,
   output logic               busy,
   output logic               done,
`ifdef HDC_REJECT_THRESH_EN
   input  logic [SCORE_W-1:0] reject_thresh,
   output logic               reject,
`endif
   output logic [LBL_W-1:0]   pred_label,
   output logic [SCORE_W-1:0] best_score
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_RESULT
   } state_t;

   localparam logic [CK_W-1:0]  LAST_CK = CK_W'(CHUNKS - 1);
   localparam logic [LBL_W-1:0] LAST_CL = LBL_W'(NUM_C - 1);

   state_t             state_q;
   logic               cls_ready_q;
   logic [LBL_W-1:0]   cls_class_q;
   logic [CK_W-1:0]    cls_chunk_q;
   logic               busy_q;
   logic               done_q;
   logic               drain_q;
   logic [LBL_W-1:0]   pred_label_q;
   logic [SCORE_W-1:0] best_score_q;

   logic               s1_vld_q;
   logic [SCORE_W-1:0] s1_pc_q;
   logic [LBL_W-1:0]   s1_cls_q;
   logic               s1_last_q;
   logic [SCORE_W-1:0] acc_q;
   logic               bst_vld_q;
   logic [LBL_W-1:0]   bst_lbl_q;
   logic [SCORE_W-1:0] bst_sc_q;

   logic               xfer;
   logic               go;
   logic [LANES-1:0]   q_chunk;
   logic [LANES-1:0]   match;
   logic [SCORE_W-1:0] pc_d;
   logic [SCORE_W-1:0] score_d;
   logic               better;

`ifdef HDC_REJECT_THRESH_EN
   logic [SCORE_W-1:0] thr_q;
   logic               reject_q;
`endif

   assign xfer = cls_valid && cls_ready_q;
   assign go = (state_q == S_IDLE) && start;

   // Select the query chunk that lines up with the expected beat.
   always_comb begin
      q_chunk = '0;
      for (int k = 0; k < CHUNKS; k++) begin
         if (cls_chunk_q == CK_W'(k)) begin
            q_chunk = in_hv[k*LANES +: LANES];
         end
      end
   end

   // Count matching bits between query chunk and class beat.
   always_comb begin
      match = ~(q_chunk ^ cls_data);
      pc_d = '0;
      for (int i = 0; i < LANES; i++) begin
         pc_d = pc_d + SCORE_W'(match[i]);
      end
   end

   // Accumulate score and decide whether the class beats the best so far.
   always_comb begin
      score_d = acc_q + s1_pc_q;
      better = !bst_vld_q || (score_d > bst_sc_q);
   end

   // Control FSM: beat sequencing, drain timing and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cls_ready_q <= 1'b0;
         cls_class_q <= '0;
         cls_chunk_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         drain_q <= 1'b0;
         pred_label_q <= '0;
         best_score_q <= '0;
`ifdef HDC_REJECT_THRESH_EN
         thr_q <= '0;
         reject_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_FETCH;
                  cls_ready_q <= 1'b1;
                  busy_q <= 1'b1;
                  cls_class_q <= '0;
                  cls_chunk_q <= '0;
`ifdef HDC_REJECT_THRESH_EN
                  thr_q <= reject_thresh;
`endif
               end
            end
            S_FETCH: begin
               if (xfer) begin
                  if (cls_chunk_q == LAST_CK) begin
                     cls_chunk_q <= '0;
                     if (cls_class_q == LAST_CL) begin
                        state_q <= S_DRAIN;
                        cls_ready_q <= 1'b0;
                        drain_q <= 1'b0;
                     end else begin
                        cls_class_q <= cls_class_q + LBL_W'(1);
                     end
                  end else begin
                     cls_chunk_q <= cls_chunk_q + CK_W'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (drain_q) begin
                  state_q <= S_RESULT;
               end
               drain_q <= 1'b1;
            end
            S_RESULT: begin
               state_q <= S_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
               pred_label_q <= bst_lbl_q;
               best_score_q <= bst_sc_q;
`ifdef HDC_REJECT_THRESH_EN
               reject_q <= (bst_sc_q < thr_q);
`endif
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Stage 1: register the per-beat popcount with its class tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s1_pc_q <= '0;
         s1_cls_q <= '0;
         s1_last_q <= 1'b0;
      end else begin
         s1_vld_q <= xfer;
         if (xfer) begin
            s1_pc_q <= pc_d;
            s1_cls_q <= cls_class_q;
            s1_last_q <= (cls_chunk_q == LAST_CK);
         end
      end
   end

   // Stage 2: per-class accumulation and running argmax.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         bst_vld_q <= 1'b0;
         bst_lbl_q <= '0;
         bst_sc_q <= '0;
      end else if (go) begin
         acc_q <= '0;
         bst_vld_q <= 1'b0;
      end else if (s1_vld_q) begin
         if (s1_last_q) begin
            acc_q <= '0;
            if (better) begin
               bst_vld_q <= 1'b1;
               bst_lbl_q <= s1_cls_q;
               bst_sc_q <= score_d;
            end
         end else begin
            acc_q <= score_d;
         end
      end
   end

   assign cls_ready = cls_ready_q;
   assign cls_class = cls_class_q;
   assign cls_chunk = cls_chunk_q;
   assign busy = busy_q;
   assign done = done_q;
   assign pred_label = pred_label_q;
   assign best_score = best_score_q;
`ifdef HDC_REJECT_THRESH_EN
   assign reject = reject_q;
`endif

endmodule
